// File: rtl/vtc_line_rd_sched.sv
// -----------------------------------------------------------------------------
// vtc_line_rd_sched
//
// Frame-buffer read scheduler driven by the video timing generator (vs/de).
// At each frame start it picks the newest completed frame buffer. It then
// issues fixed-size burst read requests line by line, and never runs more
// than LINE_PREFETCH lines ahead of the lines already displayed.
//
// Optional feature macro: VTC_SCHED_STAT_EN
//   defined   -> underflow_cnt_o is a saturating count of underflow pulses
//   undefined -> underflow_cnt_o is tied to zero and no counter is built
//
// Ports
//   vtc_clk_i        in   1       pixel clock
//   vtc_rstn_i       in   1       asynchronous active-low reset
//   vtc_vs_i         in   1       vertical sync, active high
//   vtc_de_i         in   1       data enable
//   wr_fb_idx_i      in   2       newest fully written frame buffer
//   rd_req_o         out  1       burst read request
//   rd_addr_o        out  ADDR_W  byte address of requested burst
//   rd_ack_i         in   1       request accepted by read master
//   rd_fb_idx_o      out  2       frame buffer currently being read
//   underflow_o      out  1       1-cycle pulse: line shown before fully requested
//   underflow_cnt_o  out  16      saturating underflow count (optional)
// -----------------------------------------------------------------------------
module vtc_line_rd_sched #(
  parameter int unsigned       H_ACTIVE      = 1920,
  parameter int unsigned       V_ACTIVE      = 1080,
  parameter int unsigned       BYTES_PER_PIX = 4,
  parameter int unsigned       BURST_BYTES   = 256,
  parameter int unsigned       ADDR_W        = 32,
  parameter logic [ADDR_W-1:0] FB_BASE       = 32'h0100_0000,
  parameter logic [ADDR_W-1:0] FB_STRIDE     = 32'h0080_0000,
  parameter int unsigned       NUM_FB        = 3,
  parameter int unsigned       LINE_PREFETCH = 2
) (
  input  logic              vtc_clk_i,
  input  logic              vtc_rstn_i,
  input  logic              vtc_vs_i,
  input  logic              vtc_de_i,
  input  logic [1:0]        wr_fb_idx_i,
  output logic              rd_req_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  input  logic              rd_ack_i,
  output logic [1:0]        rd_fb_idx_o,
  output logic              underflow_o,
  output logic [15:0]       underflow_cnt_o
);

  localparam int unsigned BPL  = H_ACTIVE * BYTES_PER_PIX / BURST_BYTES;
  localparam int unsigned BI_W = (BPL > 1) ? $clog2(BPL) : 1;
  localparam int unsigned LN_W = $clog2(V_ACTIVE + 1);
  // Four spare bits so that disp_line + LINE_PREFETCH (<= 7) cannot wrap.
  localparam int unsigned AH_W = LN_W + 4;

  localparam logic [LN_W-1:0]   V_ACT_C      = LN_W'(V_ACTIVE);
  localparam logic [BI_W-1:0]   BURST_LAST_C = BI_W'(BPL - 1);
  localparam logic [AH_W-1:0]   PREFETCH_C   = AH_W'(LINE_PREFETCH);
  localparam logic [ADDR_W-1:0] BURST_C      = ADDR_W'(BURST_BYTES);
  localparam logic [1:0]        FB_MAX_C     = 2'(NUM_FB - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FSTART,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic              vs_q, de_q;
  logic              vs_pend_q, vs_pend_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [1:0]        fb_idx_q, fb_idx_d;
  logic [LN_W-1:0]   req_line_q, req_line_d;
  logic [LN_W-1:0]   disp_line_q, disp_line_d;
  logic [BI_W-1:0]   burst_idx_q, burst_idx_d;
  logic              underflow_q, underflow_d;

  logic              vs_rise, de_rise, de_fall;
  logic [1:0]        fb_sel;
  logic [ADDR_W-1:0] fb_base;

  assign vs_rise = vtc_vs_i & ~vs_q;
  assign de_rise = vtc_de_i & ~de_q;
  assign de_fall = ~vtc_de_i & de_q;

  // An index pointing past the last buffer falls back to the last buffer.
  assign fb_sel  = (wr_fb_idx_i > FB_MAX_C) ? FB_MAX_C : wr_fb_idx_i;
  assign fb_base = FB_BASE + ADDR_W'(fb_sel) * FB_STRIDE;

  // True when the requested lines are LINE_PREFETCH or more ahead of display.
  // A display count that has passed the request count (underflow) reads as
  // "not ahead", so requesting resumes.
  function automatic logic ahead_full(input logic [LN_W-1:0] req,
                                      input logic [LN_W-1:0] disp);
    return {4'b0000, req} >= ({4'b0000, disp} + PREFETCH_C);
  endfunction

  assign underflow_d = de_rise & (req_line_q <= disp_line_q);

  always_comb begin
    state_d     = state_q;
    vs_pend_d   = vs_pend_q;
    rd_addr_d   = rd_addr_q;
    fb_idx_d    = fb_idx_q;
    req_line_d  = req_line_q;
    disp_line_d = disp_line_q;
    burst_idx_d = burst_idx_q;

    // Display progress counts every end of line, up to one frame's worth.
    if (de_fall && (disp_line_q < V_ACT_C)) begin
      disp_line_d = disp_line_q + LN_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (vs_rise) state_d = S_FSTART;
      end
      S_FSTART: begin
        fb_idx_d    = fb_sel;
        rd_addr_d   = fb_base;
        req_line_d  = '0;
        disp_line_d = '0;
        burst_idx_d = '0;
        vs_pend_d   = 1'b0;
        state_d     = S_ISSUE;
      end
      S_ISSUE: begin
        // A frame start seen mid-handshake is held until the ack arrives,
        // so the request is never withdrawn unaccepted.
        if (vs_rise) vs_pend_d = 1'b1;
        if (rd_ack_i) begin
          rd_addr_d = rd_addr_q + BURST_C;
          if (burst_idx_q == BURST_LAST_C) begin
            burst_idx_d = '0;
            req_line_d  = req_line_q + LN_W'(1);
          end else begin
            burst_idx_d = burst_idx_q + BI_W'(1);
          end
          if (vs_pend_q || vs_rise) begin
            state_d = S_FSTART;
          end else if (req_line_d == V_ACT_C) begin
            state_d = S_DONE;
          end else if (ahead_full(req_line_d, disp_line_d)) begin
            state_d = S_WAIT;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_WAIT: begin
        if (vs_rise) begin
          state_d = S_FSTART;
        end else if (!ahead_full(req_line_d, disp_line_d)) begin
          state_d = S_ISSUE;
        end
      end
      S_DONE: begin
        if (vs_rise) state_d = S_FSTART;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge vtc_clk_i or negedge vtc_rstn_i) begin
    if (!vtc_rstn_i) begin
      state_q     <= S_IDLE;
      vs_q        <= 1'b0;
      de_q        <= 1'b0;
      vs_pend_q   <= 1'b0;
      rd_addr_q   <= '0;
      fb_idx_q    <= '0;
      req_line_q  <= '0;
      disp_line_q <= '0;
      burst_idx_q <= '0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      vs_q        <= vtc_vs_i;
      de_q        <= vtc_de_i;
      vs_pend_q   <= vs_pend_d;
      rd_addr_q   <= rd_addr_d;
      fb_idx_q    <= fb_idx_d;
      req_line_q  <= req_line_d;
      disp_line_q <= disp_line_d;
      burst_idx_q <= burst_idx_d;
      underflow_q <= underflow_d;
    end
  end

  // Request follows the state directly so an async reset drops it at once.
  assign rd_req_o    = (state_q == S_ISSUE);
  assign rd_addr_o   = rd_addr_q;
  assign rd_fb_idx_o = fb_idx_q;
  assign underflow_o = underflow_q;

`ifdef VTC_SCHED_STAT_EN
  logic [15:0] uf_cnt_q, uf_cnt_d;

  always_comb begin
    uf_cnt_d = uf_cnt_q;
    if (underflow_q && (uf_cnt_q != 16'hFFFF)) begin
      uf_cnt_d = uf_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge vtc_clk_i or negedge vtc_rstn_i) begin
    if (!vtc_rstn_i) begin
      uf_cnt_q <= '0;
    end else begin
      uf_cnt_q <= uf_cnt_d;
    end
  end

  assign underflow_cnt_o = uf_cnt_q;
`else
  assign underflow_cnt_o = 16'd0;
`endif

endmodule
